// File: rtl/p2s_tx.sv
// p2s_tx - parallel-to-serial transmitter feeding the s2p_w_oe serial input stage.
//
// Accepts DATA_W-bit words on a valid/ready handshake and shifts them out
// MSB first on sout, holding each bit for CLK_DIV clocks. A one-cycle
// st_clk strobe follows the last bit of every word.
//
// Optional feature macro: P2S_TX_SKID_EN
//   Defined   - one-entry holding register; a word can be accepted while
//               another is being shifted, and it starts straight out of LATCH.
//   Undefined - no holding register; din_ready only while idle.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   din        in   DATA_W  parallel word to transmit
//   din_valid  in   1       din holds a word
//   din_ready  out  1       block accepts din this cycle
//   sout       out  1       serial data, MSB first, registered
//   st_clk     out  1       one-cycle strobe after the last bit, registered
//   busy       out  1       word being shifted or latched, registered

module p2s_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              st_clk,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;
    logic [DW-1:0]     r_div_cnt;
    logic              r_sout;
    logic              r_st_clk;
    logic              r_busy;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold;
    logic              w_xfer;

`ifdef P2S_TX_SKID_EN
    assign din_ready = (r_state == IDLE) | ~r_hold_valid;
`else
    assign din_ready = (r_state == IDLE);
`endif

    assign w_xfer = din_valid & din_ready;
    assign sout   = r_sout;
    assign st_clk = r_st_clk;
    assign busy   = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_sout       <= 1'b0;
            r_st_clk     <= 1'b0;
            r_busy       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_st_clk <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_shreg   <= din;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                        r_sout    <= din[DATA_W-1];
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_sout    <= 1'b0;
                            r_st_clk  <= 1'b1;
                            r_state   <= LATCH;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                            // sout is registered, so present the bit that is
                            // about to become the MSB after this shift
                            r_sout    <= r_shreg[DATA_W-2];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DW'(1);
                    end
`ifdef P2S_TX_SKID_EN
                    if (w_xfer) begin
                        r_hold       <= din;
                        r_hold_valid <= 1'b1;
                    end
`endif
                end
                LATCH: begin
`ifdef P2S_TX_SKID_EN
                    // A held word (or one handshaked during LATCH itself)
                    // starts without passing through IDLE
                    if (r_hold_valid || w_xfer) begin
                        r_shreg      <= r_hold_valid ? r_hold : din;
                        r_sout       <= r_hold_valid ? r_hold[DATA_W-1] : din[DATA_W-1];
                        r_hold_valid <= 1'b0;
                        r_bit_cnt    <= '0;
                        r_div_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_sout  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// tb_p2s_tx - bench for p2s_tx with two instances (CLK_DIV = 1 and 3).
// Expected outputs come from a schedule of accepted words: each word has a
// start edge S, and its waveform over the following periods is derived from
// plain arithmetic on S, DATA_W and CLK_DIV.
// Build with +define+P2S_TX_SKID_EN to exercise the holding-register variant.

module tb_p2s_tx;

    localparam int N   = 8;
    localparam int NI  = 2;
    localparam int QSZ = 4096;
`ifdef P2S_TX_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int GAP  = 1;
`else
    localparam bit SKID = 1'b0;
    localparam int GAP  = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [N-1:0]  din = '0;
    logic [NI-1:0] rdy, so, st, bz;

    always #5 clk = ~clk;

    p2s_tx #(.DATA_W(8), .CLK_DIV(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .sout(so[0]), .st_clk(st[0]), .busy(bz[0])
    );

    p2s_tx #(.DATA_W(8), .CLK_DIV(3)) u_dut_d3 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .sout(so[1]), .st_clk(st[1]), .busy(bz[1])
    );

    int           s_start [NI][QSZ];
    logic [N-1:0] s_word  [NI][QSZ];
    int           head [NI];
    int           tail [NI];
    int           xfer_cnt [NI];
    int           xfer_log [$];
    int           p;
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (period %0d)", tag, obs, exp, p);
        end
    endtask

    // Period in which the last scheduled word strobes, -1 if none
    function automatic int last_end(input int i);
        if (tail[i] == 0) return -1;
        return s_start[i][tail[i]-1] + N * div_of(i);
    endfunction

    function automatic logic exp_ready(input int i, input int pp);
        logic idle, hold;
        idle = (pp > last_end(i));
        hold = (tail[i] > 0) && (s_start[i][tail[i]-1] > pp);
        return SKID ? (idle || !hold) : idle;
    endfunction

    // Handshake at the edge ending period pp
    task automatic schedule(input int i, input int pp, input logic [N-1:0] d);
        int s;
        s = (pp > last_end(i)) ? pp + 1 : last_end(i) + 1;
        if (tail[i] < QSZ) begin
            s_start[i][tail[i]] = s;
            s_word[i][tail[i]]  = d;
            tail[i]++;
        end
    endtask

    task automatic exp_out(input int i, input int pp, output logic eso, output logic est, output logic ebz);
        int off;
        eso = 1'b0; est = 1'b0; ebz = 1'b0;
        while (head[i] < tail[i] && s_start[i][head[i]] + N * div_of(i) < pp) head[i]++;
        if (head[i] < tail[i] && s_start[i][head[i]] <= pp) begin
            off = pp - s_start[i][head[i]];
            ebz = 1'b1;
            if (off == N * div_of(i)) est = 1'b1;
            else eso = s_word[i][head[i]][N-1-off/div_of(i)];
        end
    endtask

    task automatic check_outputs();
        logic eso, est, ebz;
        for (int i = 0; i < NI; i++) begin
            exp_out(i, p, eso, est, ebz);
            check($sformatf("sout%0d", i), so[i], eso);
            check($sformatf("st_clk%0d", i), st[i], est);
            check($sformatf("busy%0d", i), bz[i], ebz);
        end
    endtask

    // Drive one period of stimulus, then check the outputs after the edge
    task automatic cycle(input logic v, input logic [N-1:0] d);
        logic er;
        din_valid = v;
        din       = d;
        for (int i = 0; i < NI; i++) begin
            er = exp_ready(i, p);
            check($sformatf("ready%0d", i), rdy[i], er);
            if (v && er) begin
                schedule(i, p, d);
                xfer_cnt[i]++;
                if (i == 0) xfer_log.push_back(p + 1);
            end
        end
        @(posedge clk);
        p++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    initial begin
        int base, budget;
        p = 0;
        clear_model();
        for (int i = 0; i < NI; i++) xfer_cnt[i] = 0;

        // Reset, then 20 idle periods
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        repeat (20) cycle(1'b0, '0);

        // Single word A5 on both instances
        cycle(1'b1, 8'hA5);
        repeat (30) cycle(1'b0, '0);

        // 81: first and last bits high, checks bit hold with CLK_DIV=3
        cycle(1'b1, 8'h81);
        repeat (30) cycle(1'b0, '0);

        // Back-to-back with din_valid held high
        xfer_log.delete();
        cycle(1'b1, 8'h01);
        repeat (25) cycle(1'b1, 8'hFF);
        check("gap", (xfer_log.size() >= 2) ? xfer_log[1] - xfer_log[0] : -1, GAP);
        repeat (40) cycle(1'b0, '0);

        // Reset in the middle of 3C (bit 4 on the CLK_DIV=1 instance)
        cycle(1'b1, 8'h3C);
        repeat (4) cycle(1'b0, '0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_sout%0d", i), so[i], 1'b0);
            check($sformatf("rst_busy%0d", i), bz[i], 1'b0);
            check($sformatf("rst_st%0d", i), st[i], 1'b0);
        end
        clear_model();
        @(negedge clk);
        check_outputs();
        repeat (2) cycle(1'b0, '0);
        rst = 1'b0;
        cycle(1'b1, 8'h5A);
        repeat (40) cycle(1'b0, '0);

        // Random valid toggling, din changing every period
        base   = xfer_cnt[0];
        budget = 0;
        while (xfer_cnt[0] - base < 200 && budget < 20000) begin
            cycle(1'($urandom_range(0, 1)), N'($urandom));
            budget++;
        end
        check("rand_words", (xfer_cnt[0] - base >= 200) ? 1 : 0, 1);
        repeat (60) cycle(1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
